store_ctrl: RTL and testbench
=============================

STORE_CTRL -- requirements
Module: store_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 15; maximum WRITE cycles allowed without mem_ack.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 instr_valid  in  1  requester presents a store instruction.
REQ-005 instr_ready  out  1  controller can accept an instruction.
REQ-006 instruction  in  32  MIPS I-type word: opcode[31:26], rs[25:21], rt[20:16], imm[15:0].
REQ-007 Read_data1  in  32  base register value (rs).
REQ-008 Read_data2  in  32  store data register value (rt).
REQ-009 address  out  32  word-aligned memory address.
REQ-010 write_enable  out  1  memory write strobe.
REQ-011 byte_en  out  4  byte lane enables; bit n covers write_data[8n+7:8n].
REQ-012 write_data  out  32  lane-replicated store data.
REQ-013 mem_ack  in  1  memory accepted the write.
REQ-014 done  out  1  one-cycle pulse on store completion.
REQ-015 fault  out  1  one-cycle pulse on aborted store.
REQ-016 fault_code  out  2  00 none, 01 misaligned, 10 illegal opcode, 11 timeout.

Function
REQ-017 States SHALL be: IDLE, DECODE, WRITE, DONE, FAULT.
REQ-018 instr_ready SHALL be 1 only in IDLE and only when reset is low.
REQ-019 Accept = instr_valid & instr_ready at a rising edge; instruction, Read_data1 and Read_data2 are registered; the FSM moves to DECODE and clears fault_code to 00.
REQ-020 DECODE SHALL compute EA = Read_data1 + sign-extended imm, modulo 2^32, with wrap-around and no overflow flag.
REQ-021 Legal opcodes: 0x2B sw, 0x29 sh, 0x28 sb; any other opcode SHALL go to FAULT with code 10.
REQ-022 Misalignment is sw with EA[1:0]!=0, or sh with EA[0]!=0; it SHALL go to FAULT with code 01; write_enable is never asserted for it.
REQ-023 Otherwise DECODE -> WRITE.
REQ-024 In WRITE: address={EA[31:2],2'b00} and write_enable=1, with all of address, write_enable, byte_en and write_data registered and stable until exit.
REQ-025 sw: byte_en=1111, write_data=rt.
REQ-026 sh: byte_en=0011 if EA[1]=0, else 1100; write_data={2{rt[15:0]}}.
REQ-027 sb: byte_en=0001<<EA[1:0]; write_data={4{rt[7:0]}}.
REQ-028 mem_ack high at any edge in WRITE, including the first, SHALL move the FSM to DONE; mem_ack outside WRITE SHALL be ignored.
REQ-029 A cycle counter SHALL clear on WRITE entry; if TIMEOUT WRITE cycles elapse without mem_ack, go to FAULT with code 11; mem_ack on the final cycle wins over the timeout.
REQ-030 On WRITE exit, write_enable and byte_en SHALL drop to 0; address and write_data hold their last values.
REQ-031 DONE: done=1 for one cycle, then IDLE. FAULT: fault=1 for one cycle, then IDLE.
REQ-032 fault_code SHALL hold until the next accept.
REQ-033 Minimum latency: accept at edge 0, DECODE, WRITE from edge 1, ack sampled at edge 2, done high during cycle 3, instr_ready high again in cycle 4.

Reset
REQ-034 reset high SHALL immediately (asynchronously) force state IDLE and drive all outputs to 0, including instr_ready, and clear the timeout counter.
REQ-035 Reset asserted mid-WRITE SHALL drop write_enable without waiting for a clock; the store is discarded and no done or fault is pulsed.
REQ-036 After reset deasserts, instr_ready=1 from the next cycle onward.

Verification
REQ-037 sw instruction=0xAC890004, rs=0x00000000, rt=0x12345678, mem_ack one cycle after WRITE entry -> address=0x00000004, byte_en=1111, write_data=0x12345678, single done pulse.
REQ-038 sw imm=0x0020, rs=0x0000001C, rt=0xABCDEF01, mem_ack immediate -> address=0x0000003C, byte_en=1111, done at minimum latency.
REQ-039 sb imm=0x0003, rs=0x00000000, rt=0xABCDEF01 -> address=0x00000000, byte_en=1000, write_data=0x01010101.
REQ-040 sw imm=0x0022, rs=0x0000001C (EA=0x3E) -> fault pulse, fault_code=01, write_enable never high; opcode 0x23 -> fault_code=10.
REQ-041 sh with mem_ack held low -> write_enable high for exactly 15 cycles, then fault_code=11; negative imm 0xFFFC with rs=0x00000002 -> EA=0xFFFFFFFE, address=0xFFFFFFFC, byte_en=1100.
REQ-042 Assert reset during WRITE between clock edges -> write_enable, done and fault are all 0 immediately, and instr_ready=1 one cycle after deassert.

Source files
------------

// File: rtl/store_ctrl_if.sv
// ---------------------------------------------------------------------------
// store_ctrl_if
// Bundles the store controller's requester handshake, memory write bus and
// completion/status signals.
//   Requester side : instr_valid, instr_ready, instruction, Read_data1, Read_data2
//   Memory side    : address, write_enable, byte_en, write_data, mem_ack
//   Status         : done, fault, fault_code
// Modports:
//   master - the environment (requester + memory) driving the controller
//   slave  - the store controller itself
// ---------------------------------------------------------------------------
interface store_ctrl_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] Read_data1;
  logic [31:0] Read_data2;
  logic [31:0] address;
  logic        write_enable;
  logic [3:0]  byte_en;
  logic [31:0] write_data;
  logic        mem_ack;
  logic        done;
  logic        fault;
  logic [1:0]  fault_code;

  modport master (
    output instr_valid, instruction, Read_data1, Read_data2, mem_ack,
    input  instr_ready, address, write_enable, byte_en, write_data,
           done, fault, fault_code
  );

  modport slave (
    input  instr_valid, instruction, Read_data1, Read_data2, mem_ack,
    output instr_ready, address, write_enable, byte_en, write_data,
           done, fault, fault_code
  );
endinterface

// File: rtl/store_ctrl.sv
// ---------------------------------------------------------------------------
// store_ctrl
// Executes one MIPS store (sw/sh/sb) at a time: accepts the instruction and
// its register operands, computes the effective address, checks opcode and
// alignment, drives a registered memory write until mem_ack or a timeout, and
// reports the outcome with a one-cycle done or fault pulse.
// Ports:
//   clk   - single clock, rising edge
//   reset - asynchronous, active-high; forces IDLE with every output at 0
//   bus   - store_ctrl_if.slave (handshake, memory bus, status)
// Parameter:
//   TIMEOUT - WRITE cycles allowed without mem_ack before a timeout fault
// ---------------------------------------------------------------------------
module store_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  store_ctrl_if.slave bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_WRITE  = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_FAULT  = 3'd4;

  localparam logic [5:0] OP_SW = 6'h2B;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SB = 6'h28;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_ILLEGAL  = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

  // Counter only needs to reach TIMEOUT-1 (the last allowed WRITE cycle).
  localparam int             CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [5:0]    opcode_q, opcode_d;
  logic [15:0]   imm_q, imm_d;
  logic [31:0]   rd1_q, rd1_d;
  logic [31:0]   rd2_q, rd2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   address_q, address_d;
  logic          write_enable_q, write_enable_d;
  logic [3:0]    byte_en_q, byte_en_d;
  logic [31:0]   write_data_q, write_data_d;
  logic          instr_ready_q, instr_ready_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;
  logic [1:0]    fault_code_q, fault_code_d;

  logic          accept_s;
  logic [31:0]   ea_s;
  logic          legal_s;
  logic          misalign_s;
  logic [3:0]    lane_be_s;
  logic [31:0]   lane_data_s;
  logic          unused_fields_s;

  // rs/rt register numbers are resolved upstream; only their values arrive here.
  assign unused_fields_s = ^bus.instruction[25:16];

  assign accept_s = bus.instr_valid & instr_ready_q;
  // Effective address wraps modulo 2^32 by construction of the 32-bit add.
  assign ea_s     = rd1_q + {{16{imm_q[15]}}, imm_q};

  // Opcode legality, alignment check and byte-lane steering for the decoded store.
  always_comb begin
    legal_s     = 1'b0;
    misalign_s  = 1'b0;
    lane_be_s   = 4'b0000;
    lane_data_s = 32'h0000_0000;
    case (opcode_q)
      OP_SW: begin
        legal_s     = 1'b1;
        misalign_s  = (ea_s[1:0] != 2'b00);
        lane_be_s   = 4'b1111;
        lane_data_s = rd2_q;
      end
      OP_SH: begin
        legal_s     = 1'b1;
        misalign_s  = ea_s[0];
        if (ea_s[1]) begin
          lane_be_s = 4'b1100;
        end else begin
          lane_be_s = 4'b0011;
        end
        lane_data_s = {2{rd2_q[15:0]}};
      end
      OP_SB: begin
        legal_s     = 1'b1;
        misalign_s  = 1'b0;
        lane_be_s   = 4'b0001 << ea_s[1:0];
        lane_data_s = {4{rd2_q[7:0]}};
      end
      default: begin
        legal_s     = 1'b0;
        misalign_s  = 1'b0;
        lane_be_s   = 4'b0000;
        lane_data_s = 32'h0000_0000;
      end
    endcase
  end

  // Next-state and next-output logic; outputs are registered against state_d
  // so they line up with the state they belong to.
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    imm_d        = imm_q;
    rd1_d        = rd1_q;
    rd2_d        = rd2_q;
    cnt_d        = cnt_q;
    address_d    = address_q;
    byte_en_d    = byte_en_q;
    write_data_d = write_data_q;
    fault_code_d = fault_code_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          opcode_d     = bus.instruction[31:26];
          imm_d        = bus.instruction[15:0];
          rd1_d        = bus.Read_data1;
          rd2_d        = bus.Read_data2;
          fault_code_d = FC_NONE;
          state_d      = ST_DECODE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (!legal_s) begin
          fault_code_d = FC_ILLEGAL;
          state_d      = ST_FAULT;
        end else if (misalign_s) begin
          fault_code_d = FC_MISALIGN;
          state_d      = ST_FAULT;
        end else begin
          cnt_d        = {CW{1'b0}};
          address_d    = {ea_s[31:2], 2'b00};
          byte_en_d    = lane_be_s;
          write_data_d = lane_data_s;
          state_d      = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // An ack on the last allowed cycle beats the timeout.
        if (bus.mem_ack) begin
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          fault_code_d = FC_TIMEOUT;
          state_d      = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Strobes live only in WRITE; address and data keep their last values.
    write_enable_d = (state_d == ST_WRITE);
    if (state_d != ST_WRITE) begin
      byte_en_d = 4'b0000;
    end else begin
      byte_en_d = byte_en_d;
    end
    instr_ready_d = (state_d == ST_IDLE);
    done_d        = (state_d == ST_DONE);
    fault_d       = (state_d == ST_FAULT);
  end

  // State, operand and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      opcode_q       <= 6'd0;
      imm_q          <= 16'd0;
      rd1_q          <= 32'd0;
      rd2_q          <= 32'd0;
      cnt_q          <= {CW{1'b0}};
      address_q      <= 32'd0;
      write_enable_q <= 1'b0;
      byte_en_q      <= 4'd0;
      write_data_q   <= 32'd0;
      instr_ready_q  <= 1'b0;
      done_q         <= 1'b0;
      fault_q        <= 1'b0;
      fault_code_q   <= 2'd0;
    end else begin
      state_q        <= state_d;
      opcode_q       <= opcode_d;
      imm_q          <= imm_d;
      rd1_q          <= rd1_d;
      rd2_q          <= rd2_d;
      cnt_q          <= cnt_d;
      address_q      <= address_d;
      write_enable_q <= write_enable_d;
      byte_en_q      <= byte_en_d;
      write_data_q   <= write_data_d;
      instr_ready_q  <= instr_ready_d;
      done_q         <= done_d;
      fault_q        <= fault_d;
      fault_code_q   <= fault_code_d;
    end
  end

  assign bus.instr_ready  = instr_ready_q;
  assign bus.address      = address_q;
  assign bus.write_enable = write_enable_q;
  assign bus.byte_en      = byte_en_q;
  assign bus.write_data   = write_data_q;
  assign bus.done         = done_q;
  assign bus.fault        = fault_q;
  assign bus.fault_code   = fault_code_q;

endmodule

// File: tb/tb_store_ctrl.sv
// ---------------------------------------------------------------------------
// tb_store_ctrl
// Directed, self-checking bench for store_ctrl: reset state, sw/sh/sb lane
// steering, minimum latency, misaligned and illegal faults, timeout, ack on
// the last allowed cycle, ignored stray ack and asynchronous reset mid-write.
// ---------------------------------------------------------------------------
module tb_store_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   we_cycles;
  int   done_seen;

  store_ctrl_if bus();

  store_ctrl #(.TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an instruction for one edge; returns just after the accept edge.
  task automatic send(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
    chk("ready_before_send", {31'd0, bus.instr_ready}, 32'd1);
    bus.instruction = instr;
    bus.Read_data1  = rs;
    bus.Read_data2  = rt;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instruction = 32'd0;
    bus.Read_data1  = 32'd0;
    bus.Read_data2  = 32'd0;
    bus.mem_ack     = 1'b0;
    repeat (2) tick();
    chk("rst_ready", {31'd0, bus.instr_ready}, 32'd0);
    chk("rst_we",    {31'd0, bus.write_enable}, 32'd0);
    chk("rst_addr",  bus.address, 32'd0);
    chk("rst_fc",    {30'd0, bus.fault_code}, 32'd0);
    reset = 1'b0;
    tick();
    chk("ready_after_rst", {31'd0, bus.instr_ready}, 32'd1);

    // Stray ack in IDLE must be ignored.
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("stray_ack_done",  {31'd0, bus.done}, 32'd0);
    chk("stray_ack_ready", {31'd0, bus.instr_ready}, 32'd1);

    // sw 0xAC890004, ack one cycle after WRITE entry.
    send(32'hAC89_0004, 32'h0000_0000, 32'h1234_5678);
    tick();
    chk("sw1_we",   {31'd0, bus.write_enable}, 32'd1);
    chk("sw1_addr", bus.address, 32'h0000_0004);
    chk("sw1_be",   {28'd0, bus.byte_en}, 32'hF);
    chk("sw1_data", bus.write_data, 32'h1234_5678);
    tick();
    chk("sw1_we_hold", {31'd0, bus.write_enable}, 32'd1);
    chk("sw1_done_early", {31'd0, bus.done}, 32'd0);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("sw1_done", {31'd0, bus.done}, 32'd1);
    chk("sw1_we_drop", {31'd0, bus.write_enable}, 32'd0);
    chk("sw1_be_drop", {28'd0, bus.byte_en}, 32'd0);
    chk("sw1_addr_hold", bus.address, 32'h0000_0004);
    tick();
    chk("sw1_done_pulse", {31'd0, bus.done}, 32'd0);

    // sw imm 0x20 + 0x1C, immediate ack -> minimum latency.
    send(32'hAC00_0020, 32'h0000_001C, 32'hABCD_EF01);
    chk("sw2_decode_ready", {31'd0, bus.instr_ready}, 32'd0);
    chk("sw2_decode_we",    {31'd0, bus.write_enable}, 32'd0);
    tick();
    chk("sw2_addr", bus.address, 32'h0000_003C);
    chk("sw2_be",   {28'd0, bus.byte_en}, 32'hF);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("sw2_done", {31'd0, bus.done}, 32'd1);
    tick();
    chk("sw2_ready_again", {31'd0, bus.instr_ready}, 32'd1);

    // sb imm 3 -> top lane.
    send(32'hA000_0003, 32'h0000_0000, 32'hABCD_EF01);
    tick();
    chk("sb_addr", bus.address, 32'h0000_0000);
    chk("sb_be",   {28'd0, bus.byte_en}, 32'h8);
    chk("sb_data", bus.write_data, 32'h0101_0101);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("sb_done", {31'd0, bus.done}, 32'd1);
    tick();

    // Misaligned sw: EA = 0x3E.
    send(32'hAC00_0022, 32'h0000_001C, 32'h1111_1111);
    chk("mis_fc_cleared", {30'd0, bus.fault_code}, 32'd0);
    chk("mis_we_decode",  {31'd0, bus.write_enable}, 32'd0);
    tick();
    chk("mis_fault", {31'd0, bus.fault}, 32'd1);
    chk("mis_fc",    {30'd0, bus.fault_code}, 32'd1);
    chk("mis_we",    {31'd0, bus.write_enable}, 32'd0);
    tick();
    chk("mis_fault_pulse", {31'd0, bus.fault}, 32'd0);
    chk("mis_fc_hold",     {30'd0, bus.fault_code}, 32'd1);

    // Misaligned sh: EA = 1.
    send(32'hA400_0001, 32'h0000_0000, 32'h0);
    tick();
    chk("sh_mis_fc", {30'd0, bus.fault_code}, 32'd1);
    tick();

    // Illegal opcode 0x23.
    send(32'h8C00_0000, 32'h0000_0000, 32'h0);
    chk("ill_fc_cleared", {30'd0, bus.fault_code}, 32'd0);
    tick();
    chk("ill_fault", {31'd0, bus.fault}, 32'd1);
    chk("ill_fc",    {30'd0, bus.fault_code}, 32'd2);
    tick();

    // sh negative imm, no ack -> timeout after exactly 15 WRITE cycles.
    send(32'hA400_FFFC, 32'h0000_0002, 32'h0000_BEEF);
    tick();
    chk("sh_addr", bus.address, 32'hFFFF_FFFC);
    chk("sh_be",   {28'd0, bus.byte_en}, 32'hC);
    chk("sh_data", bus.write_data, 32'hBEEF_BEEF);
    we_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.write_enable) we_cycles++;
      if (bus.fault) break;
      tick();
    end
    chk("to_we_cycles", we_cycles, 32'd15);
    chk("to_fault", {31'd0, bus.fault}, 32'd1);
    chk("to_fc",    {30'd0, bus.fault_code}, 32'd3);
    chk("to_addr_hold", bus.address, 32'hFFFF_FFFC);
    tick();

    // Ack on the 15th (final) WRITE cycle wins over the timeout.
    send(32'hA400_0002, 32'h0000_0000, 32'h0000_1234);
    tick();
    chk("last_be", {28'd0, bus.byte_en}, 32'hC);
    repeat (14) tick();
    chk("last_we_still", {31'd0, bus.write_enable}, 32'd1);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("last_done",  {31'd0, bus.done}, 32'd1);
    chk("last_fault", {31'd0, bus.fault}, 32'd0);
    tick();

    // Reset between edges during WRITE.
    send(32'hAC00_0000, 32'h0000_0010, 32'hCAFE_F00D);
    tick();
    chk("rw_we_before", {31'd0, bus.write_enable}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rw_we",    {31'd0, bus.write_enable}, 32'd0);
    chk("rw_done",  {31'd0, bus.done}, 32'd0);
    chk("rw_fault", {31'd0, bus.fault}, 32'd0);
    chk("rw_ready", {31'd0, bus.instr_ready}, 32'd0);
    chk("rw_addr",  bus.address, 32'd0);
    tick();
    #2;
    reset = 1'b0;
    done_seen = 0;
    tick();
    chk("rw_ready_after", {31'd0, bus.instr_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (bus.done || bus.fault) done_seen++;
      tick();
    end
    chk("rw_no_pulse", done_seen, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
